// File: rtl/msg_ram_if.sv
// Request/response bundle between a message RAM client and msg_ram_dp.
// master: client (assembler / frame handlers); slave: the RAM.
interface msg_ram_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  clr_req;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [BE_WIDTH-1:0]   wr_be;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  init_busy;
   logic                  req_drop;

   modport master (
      output clr_req, wr_en, wr_addr, wr_be, wr_data,
      output rd_en, rd_addr,
      input  rd_data, rd_valid, init_busy, req_drop
   );

   modport slave (
      input  clr_req, wr_en, wr_addr, wr_be, wr_data,
      input  rd_en, rd_addr,
      output rd_data, rd_valid, init_busy, req_drop
   );
endinterface

// File: rtl/msg_ram_dp.sv
// Simple-dual-port message RAM: byte-enabled write port, registered read
// port, clear sweep after reset / on clr_req, out-of-range flagging.
// Ports: clk, rst (async, active-high), bus (msg_ram_if.slave):
//   clr_req, wr_en/wr_addr/wr_be/wr_data, rd_en/rd_addr in;
//   rd_data, rd_valid, init_busy, req_drop out.
module msg_ram_dp #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input logic      clk,
   input logic      rst,
   msg_ram_if.slave bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [ADDR_WIDTH:0] DEPTH =
      (ADDR_WIDTH+1)'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST =
      ADDR_WIDTH'(RAM_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;
   logic                  req_drop_q;

   logic                  run;
   logic                  wr_in;
   logic                  rd_in;
   logic                  wr_ok;
   logic                  same;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] rd_next;
   logic                  drop_next;

   assign run   = (state == S_RUN);
   assign wr_in = {1'b0, bus.wr_addr} < DEPTH;
   assign rd_in = {1'b0, bus.rd_addr} < DEPTH;
   assign wr_ok = run & bus.wr_en & wr_in;
   assign same  = wr_ok & (bus.wr_addr == bus.rd_addr);

   // Out-of-range addresses are steered to word 0 so the array is never
   // indexed past its end; the result is masked off anyway.
   assign wr_idx  = wr_in ? bus.wr_addr : '0;
   assign rd_idx  = rd_in ? bus.rd_addr : '0;
   assign rd_word = mem[rd_idx];

   always_comb begin
      merged = rd_word;
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (bus.wr_be[i]) begin
            merged[8*i +: 8] = bus.wr_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_next = rd_word;
      if (!rd_in) begin
         rd_next = '0;
      end else if (RDW_MODE == 1 && same) begin
         rd_next = merged;
      end
   end

   assign drop_next = (!run & (bus.wr_en | bus.rd_en))
                    | (run & bus.wr_en & !wr_in)
                    | (run & bus.rd_en & !rd_in);

   // Storage has no reset; the sweep is what initialises it.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[ptr] <= INIT_VALUE;
      end else if (wr_ok) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (bus.wr_be[i]) begin
               mem[wr_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_INIT;
         ptr        <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         req_drop_q <= 1'b0;
      end else begin
         req_drop_q <= drop_next;
         rd_valid_q <= run & bus.rd_en;
         if (run && bus.rd_en) begin
            rd_data_q <= rd_next;
         end
         if (!run) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
               state <= S_RUN;
            end
         end else if (bus.clr_req) begin
            state <= S_INIT;
            ptr   <= '0;
         end
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.req_drop  = req_drop_q;
   assign bus.init_busy = ~run;
endmodule
